// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
package mem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEPTH_DEF   = 32;
    localparam int LATENCY_DEF = 2;
    localparam int CNT_W       = 3;

endpackage

// File: rtl/data_mem_array.sv
// Doubleword storage: one synchronous write port, one combinational read port,
// and a synchronous clear that zeroes every word.
module data_mem_array #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 64,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear has priority over the write port
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with a fixed access latency.
// One request is latched in IDLE, a counter spaces it out in WAIT, and the
// memory access plus response registers all update on the edge into RESP.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             enter_resp;

    logic             lat_write;
    logic [63:0]      lat_addr;
    logic [63:0]      lat_wdata;

    logic             txn_write;
    logic [63:0]      txn_addr;
    logic [63:0]      txn_wdata;
    logic [60:0]      txn_index;
    logic             txn_err;

    logic [AW-1:0]    mem_idx;
    logic [63:0]      mem_rdata;
    logic             mem_we;

    assign accept = req_valid && (state == IDLE);

    // With LATENCY=1 the access happens on the accept edge itself, before the
    // latch holds anything, so the live request inputs are used in IDLE.
    assign txn_write = (state == IDLE) ? req_write : lat_write;
    assign txn_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign txn_wdata = (state == IDLE) ? req_wdata : lat_wdata;

    assign txn_index = txn_addr[63:3];
    assign txn_err   = (txn_addr[2:0] != 3'b000) ||
                       ({3'b000, txn_index} >= 64'(DEPTH));
    assign mem_idx   = txn_index[AW-1:0];
    assign mem_we    = enter_resp && txn_write && !txn_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_nxt  = state;
        enter_resp = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latency counter: loaded on accept, counts down while waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Request capture; later input changes cannot disturb the transaction
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Response registers, loaded on the edge into RESP and held until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err   <= txn_err;
            rsp_rdata <= (txn_write || txn_err) ? 64'd0 : mem_rdata;
        end
    end

    data_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (64),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .clr   (rst),
        .we    (mem_we),
        .waddr (mem_idx),
        .wdata (txn_wdata),
        .raddr (mem_idx),
        .rdata (mem_rdata)
    );

endmodule
